// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC fetch path.
// Combinational definitions only; no latency or flow-control behaviour.
package npc_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      EXEC  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_VEC  = 32'h8000_0000;
   localparam int          INST_BYTES = 4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: imem request/response, decode handoff, commit and status.
// master = fetch controller; slave = memory/decode/writeback side.
interface pc_fetch_ctrl_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            imem_rsp_err;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            commit_valid;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            trap;
   logic [XLEN-1:0] trap_vec;
   logic            fault;
   logic [63:0]     retired;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault, retired,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             inst_ready, commit_valid, redirect, redirect_pc, trap, trap_vec
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fault, retired,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             inst_ready, commit_valid, redirect, redirect_pc, trap, trap_vec
   );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (trap > redirect > pc+4) with target misalignment flag.
// Purely combinational; no backpressure.
module pc_next_sel #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            trap_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic [XLEN-1:0] trap_vec_i,
   output logic [XLEN-1:0] next_pc_o,
   output logic            misalign_o
);
   import npc_pkg::*;

   always_comb begin
      if (trap_i) begin
         next_pc_o = trap_vec_i;
      end else if (redirect_i) begin
         next_pc_o = redirect_pc_i;
      end else begin
         // Sequential step wraps naturally at 2^XLEN.
         next_pc_o = pc_i + XLEN'(INST_BYTES);
      end
   end

   assign misalign_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: FETCH -> WAIT -> ISSUE -> EXEC, minimum 4 cycles per instruction.
// Holds request/instruction stable under backpressure; inputs outside their state are ignored.
module pc_fetch_ctrl #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000
) (
   input  logic               clk,
   input  logic               rst,
   pc_fetch_ctrl_if.master    bus
);
   import npc_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic [63:0]     retired_q, retired_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] next_pc;
   logic            misalign;
   logic            req_hs;
   logic            rsp_take;
   logic            issue_hs;
   logic            commit;
   logic            req_valid;
   logic            inst_valid;

   assign req_hs   = (state_q == FETCH) && bus.imem_req_ready;
   assign rsp_take = (state_q == WAIT)  && bus.imem_rsp_valid;
   assign issue_hs = (state_q == ISSUE) && bus.inst_ready;
   assign commit   = (state_q == EXEC)  && bus.commit_valid;

   pc_next_sel #(
      .XLEN(XLEN)
   ) u_next_sel (
      .pc_i          (pc_q),
      .trap_i        (bus.trap),
      .redirect_i    (bus.redirect),
      .redirect_pc_i (bus.redirect_pc),
      .trap_vec_i    (bus.trap_vec),
      .next_pc_o     (next_pc),
      .misalign_o    (misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (req_hs)   state_d = WAIT;
         WAIT:    if (rsp_take) state_d = bus.imem_rsp_err ? FETCH : ISSUE;
         ISSUE:   if (issue_hs) state_d = EXEC;
         EXEC:    if (commit)   state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Handshake outputs decode state only, so no input reaches them combinationally.
   always_comb begin
      req_valid  = (state_q == FETCH);
      inst_valid = (state_q == ISSUE);
   end

   always_comb begin
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      retired_d = retired_q;
      fault_d   = 1'b0;
      if (rsp_take) begin
         if (bus.imem_rsp_err) begin
            pc_d    = bus.trap_vec;
            fault_d = 1'b1;
         end else begin
            inst_d    = bus.imem_rsp_data;
            inst_pc_d = pc_q;
         end
      end
      if (commit) begin
         retired_d = retired_q + 64'd1;
         if (misalign) begin
            pc_d    = bus.trap_vec;
            fault_d = 1'b1;
         end else begin
            pc_d = next_pc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_VEC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         retired_q <= 64'd0;
         fault_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid;
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.fault          = fault_q;
   assign bus.retired        = retired_q;

endmodule
